vpe_fea_mem_arbiter: RTL and testbench

- Shares the single read port of the main feature memory between NUM_REQ feature-address requesters (per-lane TF fetchers, debug/readback path).
- Uses round-robin arbitration and issues one read per cycle.
- Tracks in-flight reads through the fixed memory latency and routes each read word back to the requester that issued it.
- Provides a flush/drain handshake so the VPE controller can quiesce the memory port between inferences.

---
 rtl/vpe_fea_pkg.sv | 28 ++
 rtl/vpe_fea_mem_arbiter_if.sv | 41 ++++
 rtl/vpe_rr_arbiter.sv | 119 +++++++++++
 rtl/vpe_fea_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vpe_fea_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vpe_fea_pkg.sv
// ---------------------------------------------------------------------------
// vpe_fea_pkg
// Shared definitions for the VPE feature-memory arbiter slice.
//   FEA_ADDR_W      : default feature memory address width
//   fea_arb_state_e : arbiter drain/quiesce FSM states (ARB, DRAIN, DONE)
//   fea_tag_t       : requester tag for the default requester count
//   fea_tag_w()     : tag width for any requester count (min 1 bit so a
//                     single-requester build still has a legal vector)
// ---------------------------------------------------------------------------
package vpe_fea_pkg;

    localparam int FEA_ADDR_W  = 12;
    localparam int FEA_NUM_REQ = 4;
    localparam int FEA_TAG_W   = $clog2(FEA_NUM_REQ);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fea_arb_state_e;

    typedef logic [FEA_TAG_W-1:0] fea_tag_t;

    function automatic int fea_tag_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/vpe_fea_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// vpe_fea_mem_arbiter_if
// Requester-side bundle of the feature-memory arbiter.
//   req_v    : per-requester address valid
//   req_addr : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_rdy  : one-hot grant from the arbiter
//   rsp_v    : one-hot response valid from the arbiter
//   rsp_data : response data shared by all requesters
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vpe_fea_mem_arbiter_if
    import vpe_fea_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = FEA_ADDR_W,
    parameter int DATA_W  = 64
) ();

    logic [NUM_REQ-1:0]        req_v;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ-1:0]        rsp_v;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_v,
        output req_addr,
        input  req_rdy,
        input  rsp_v,
        input  rsp_data
    );

    modport slave (
        input  req_v,
        input  req_addr,
        output req_rdy,
        output rsp_v,
        output rsp_data
    );

endinterface

// File: rtl/vpe_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vpe_rr_arbiter
// Round-robin grant generator with pointer update. Reusable for any shared
// single-port memory (feature or weight).
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector
//   grant_en  : grants allowed this cycle
//   grant     : one-hot grant (zero when disabled or nothing requested)
//   grant_idx : index of the winning requester (valid when grant != 0)
// Optional macro FEA_ARB_BURST_LOCK_EN: the pointer stays on the grantee for
// up to MAX_BURST consecutive grants before it is forced to rotate.
// ---------------------------------------------------------------------------
module vpe_rr_arbiter
    import vpe_fea_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = fea_tag_w(NUM_REQ)
`ifdef FEA_ARB_BURST_LOCK_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] ptr_rot;
    logic             found;

    // Index that lies 'offs' places above 'base', wrapping at NUM_REQ
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                                 input int               offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[IDX_W-1:0];
    endfunction

    // First requester at or above the pointer, searching with wrap-around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[rot_idx(ptr, k)]) begin
                found     = 1'b1;
                grant_idx = rot_idx(ptr, k);
            end
        end
        if (grant_en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Position just past the current winner; constant 0 when NUM_REQ is 1
    assign ptr_rot = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef FEA_ARB_BURST_LOCK_EN
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    logic [BCNT_W-1:0] burst_cnt;
    logic [BCNT_W-1:0] burst_nxt;

    // A grant to the locked requester extends the burst; any other outcome
    // (idle cycle, grant elsewhere, grants disabled) restarts it
    always_comb begin
        burst_nxt = '0;
        ptr_nxt   = ptr;
        if (|grant) begin
            if ((grant_idx == ptr) && (burst_cnt != '0)) begin
                burst_nxt = burst_cnt + BCNT_W'(1);
            end else begin
                burst_nxt = BCNT_W'(1);
            end
            if (burst_nxt >= BCNT_W'(MAX_BURST)) begin
                ptr_nxt   = ptr_rot;
                burst_nxt = '0;
            end else begin
                ptr_nxt   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
        end
    end
`else
    // Strict round-robin: rotate past every winner
    always_comb begin
        ptr_nxt = ptr;
        if (|grant) begin
            ptr_nxt = ptr_rot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`endif

endmodule

// File: rtl/vpe_fea_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vpe_fea_mem_arbiter
// Shares the single read port of the main feature memory between NUM_REQ
// requesters. One read issued per cycle, round-robin; each read word is
// routed back to its issuer after the fixed memory latency. A flush/drain
// handshake lets the VPE controller quiesce the port between inferences.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : req_v/req_addr/req_rdy requests, rsp_v/rsp_data responses
//   mem_rd_addr  : registered read address to feature memory
//   mem_rd_en    : registered read strobe
//   mem_rd_data  : read data, valid RD_LAT cycles after mem_rd_en
//   flush        : stop granting and drain in-flight reads
//   flush_done   : one-cycle pulse when the drain is complete
//   busy         : reads in flight or FSM outside ARB
// Optional macro FEA_ARB_BURST_LOCK_EN enables burst lock (MAX_BURST grants).
// ---------------------------------------------------------------------------
module vpe_fea_mem_arbiter
    import vpe_fea_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = FEA_ADDR_W,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    vpe_fea_mem_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    output logic                     mem_rd_en,
    input  logic [DATA_W-1:0]        mem_rd_data,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     busy
);

    localparam int TAG_W  = fea_tag_w(NUM_REQ);
    localparam int CNT_W  = $clog2(RD_LAT + 3);
    localparam int PIPE_D = RD_LAT + 1;

    if ((NUM_REQ < 1) || (NUM_REQ > 8) || (RD_LAT < 1) || (RD_LAT > 4) || (MAX_BURST < 1)) begin : g_bad_params
        $error("vpe_fea_mem_arbiter: parameter out of range");
    end

    fea_arb_state_e     state;
    fea_arb_state_e     state_nxt;
    logic               grant_en;
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               hs;
    logic [PIPE_D-1:0]  pipe_v;
    logic [TAG_W-1:0]   pipe_tag [PIPE_D];
    logic [CNT_W-1:0]   inflight;
    logic [NUM_REQ-1:0] rsp_v_q;
    logic [NUM_REQ-1:0] rsp_v_nxt;
    logic [DATA_W-1:0]  rsp_data_q;

    vpe_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_W     (TAG_W)
`ifdef FEA_ARB_BURST_LOCK_EN
        ,
        .MAX_BURST (MAX_BURST)
`endif
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_v),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants only go to requesters with req_v set, so any grant is a transfer
    assign hs            = |grant;
    assign bus.req_rdy   = grant;
    assign bus.rsp_v     = rsp_v_q;
    assign bus.rsp_data  = rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN may fall through to DONE on its first cycle when nothing is in flight
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (flush) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0) state_nxt = DONE;
            DONE:    state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // flush blocks grants in the same cycle; reset blocks the combinational grant
    always_comb begin
        grant_en   = (state == ARB) && !flush && !rst;
        flush_done = (state == DONE);
        busy       = (state != ARB) || (inflight != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            mem_rd_en <= hs;
            if (hs) begin
                mem_rd_addr <= bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Stage k is aligned with the read issued k cycles after mem_rd_en, so the
    // last stage lines up with the cycle mem_rd_data is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int k = 0; k < PIPE_D; k++) begin
                pipe_tag[k] <= '0;
            end
        end else begin
            pipe_v      <= {pipe_v[PIPE_D-2:0], hs};
            pipe_tag[0] <= grant_idx;
            for (int k = 1; k < PIPE_D; k++) begin
                pipe_tag[k] <= pipe_tag[k-1];
            end
        end
    end

    always_comb begin
        rsp_v_nxt = '0;
        if (pipe_v[RD_LAT]) begin
            rsp_v_nxt[pipe_tag[RD_LAT]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_v_q <= rsp_v_nxt;
            if (pipe_v[RD_LAT]) begin
                rsp_data_q <= mem_rd_data;
            end
        end
    end

    // Counts from the grant until the response has been presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({hs, |rsp_v_q})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_vpe_fea_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vpe_fea_mem_arbiter
// Directed stimulus for vpe_fea_mem_arbiter with a scoreboard: every expected
// grant pushes the expected memory read and response into queues, and a
// negedge monitor pops and compares whenever the DUT presents mem_rd_en or
// rsp_v. Honours FEA_ARB_BURST_LOCK_EN for the expected grant orders.
// ---------------------------------------------------------------------------
module tb_vpe_fea_mem_arbiter;
    import vpe_fea_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 64;
    localparam int RD_LAT  = 2;

`ifdef FEA_ARB_BURST_LOCK_EN
    localparam logic [3:0] C_EXP [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000};
    localparam logic [3:0] F_EXP [3] = '{4'b0010, 4'b0010, 4'b0010};
    localparam logic [3:0] G_EXP [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                         4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
    localparam logic [3:0] C_EXP [4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
    localparam logic [3:0] F_EXP [3] = '{4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] G_EXP [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                         4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } rd_exp_t;

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] vec;
        logic [DATA_W-1:0]  data;
    } rsp_exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_v = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic                      flush = 1'b0;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ-1:0]        rsp_v;
    logic [DATA_W-1:0]         rsp_data;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic                      mem_rd_en;
    logic [DATA_W-1:0]         mem_rd_data;
    logic                      flush_done;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_pipe [RD_LAT];

    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;
    rd_exp_t  rd_q [$];
    rsp_exp_t rsp_q [$];
    rd_exp_t  rd_e;
    rsp_exp_t rsp_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    vpe_fea_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign bus.req_v    = req_v;
    assign bus.req_addr = req_addr;
    assign req_rdy      = bus.req_rdy;
    assign rsp_v        = bus.rsp_v;
    assign rsp_data     = bus.rsp_data;

    vpe_fea_mem_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .flush       (flush),
        .flush_done  (flush_done),
        .busy        (busy)
    );

    // Memory word content is a recognisable function of its address
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {20'hFEA01, a, 20'h5A5A5, a};
    endfunction

    function automatic logic [NUM_REQ*ADDR_W-1:0] pack4(input logic [ADDR_W-1:0] a3,
                                                        input logic [ADDR_W-1:0] a2,
                                                        input logic [ADDR_W-1:0] a1,
                                                        input logic [ADDR_W-1:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // Feature memory model with RD_LAT cycles of read latency
    always @(posedge clk) begin
        mem_pipe[0] <= mem_rd_addr;
        for (int k = 1; k < RD_LAT; k++) begin
            mem_pipe[k] <= mem_pipe[k-1];
        end
    end
    assign mem_rd_data = mem_word(mem_pipe[RD_LAT-1]);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req_rdy", req_rdy, 0);
        checkOutput("rst_mem_rd_en", mem_rd_en, 0);
        checkOutput("rst_mem_rd_addr", mem_rd_addr, 0);
        checkOutput("rst_rsp_v", rsp_v, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        checkOutput("rst_busy", busy, 0);
    endtask

    // One cycle of stimulus; exp_busy/exp_done < 0 means not checked
    task automatic applyStimulus(input logic [NUM_REQ-1:0]        v,
                                 input logic [NUM_REQ*ADDR_W-1:0] addrs,
                                 input logic                      fl,
                                 input logic [NUM_REQ-1:0]        exp_rdy,
                                 input int                        exp_busy,
                                 input int                        exp_done);
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        req_v    = v;
        req_addr = addrs;
        flush    = fl;
        #1;
        checkOutput("req_rdy", req_rdy, exp_rdy);
        if (exp_busy >= 0) checkOutput("busy", busy, exp_busy);
        if (exp_done >= 0) checkOutput("flush_done", flush_done, exp_done);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i]) begin
                a = addrs[i*ADDR_W +: ADDR_W];
                rd_q.push_back('{cyc + 1, a});
                rsp_q.push_back('{cyc + RD_LAT + 2, exp_rdy, mem_word(a)});
            end
        end
    endtask

    task automatic idle(input int n, input int exp_busy);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, '0, 1'b0, '0, exp_busy, 0);
        end
    endtask

    // Scoreboard monitor: compares whenever the DUT presents an output
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                if (rd_q.size() == 0) begin
                    checkOutput("mem_rd_en_unexpected", 1, 0);
                end else begin
                    rd_e = rd_q.pop_front();
                    checkOutput("mem_rd_cycle", cyc, rd_e.cyc);
                    checkOutput("mem_rd_addr", mem_rd_addr, rd_e.addr);
                end
            end
            if (|rsp_v) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("rsp_v_unexpected", rsp_v, 0);
                end else begin
                    rsp_e = rsp_q.pop_front();
                    checkOutput("rsp_cycle", cyc, rsp_e.cyc);
                    checkOutput("rsp_v", rsp_v, rsp_e.vec);
                    checkOutput("rsp_data", rsp_data, rsp_e.data);
                end
            end
        end
    end

    initial begin
        // Reset state, with every requester asking
        req_v = 4'b1111;
        #2;
        checkResetOutputs();
        @(negedge clk);
        req_v = '0;
        #2 rst = 1'b0;
        $display("[TB] reset released");

        // Single request from requester 2
        idle(2, 0);
        applyStimulus(4'b0100, pack4(12'h0, 12'h01A, 12'h0, 12'h0), 1'b0, 4'b0100, 0, 0);
        idle(5, -1);

        // Pointer wrap with requesters 0 and 3
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1001, pack4(12'h300 + 12'(k), 12'h0, 12'h0, 12'h0C0 + 12'(k)),
                          1'b0, C_EXP[k], -1, 0);
        end
        idle(6, -1);

        // Flush with two reads in flight, flush colliding with req_v[1]
        applyStimulus(4'b0010, pack4(0, 0, 12'h111, 0), 1'b0, 4'b0010, 0, 0);
        applyStimulus(4'b0010, pack4(0, 0, 12'h112, 0), 1'b0, 4'b0010, 1, 0);
        applyStimulus(4'b0010, pack4(0, 0, 12'h113, 0), 1'b1, 4'b0000, 1, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0010, pack4(0, 0, 12'h114, 0), 1'b0, 4'b0000, 1, 0);
        end
        applyStimulus(4'b0010, pack4(0, 0, 12'h115, 0), 1'b0, 4'b0000, 1, 1);
        applyStimulus(4'b0000, '0, 1'b0, 4'b0000, 0, 0);

        // Flush while idle; a second flush during DRAIN is ignored
        applyStimulus('0, '0, 1'b1, '0, 0, 0);
        applyStimulus('0, '0, 1'b1, '0, 1, 0);
        applyStimulus('0, '0, 1'b0, '0, 1, 1);
        applyStimulus('0, '0, 1'b0, '0, 0, 0);

        // Reset pulse with three reads in flight
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, pack4(12'h2A3, 12'h2A2, 12'h2A1, 12'h2A0), 1'b0, F_EXP[k], -1, 0);
        end
        @(negedge clk);
        req_v = 4'b1111;
        #2 rst = 1'b1;
        #1;
        checkResetOutputs();
        rd_q.delete();
        rsp_q.delete();
        req_v = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        idle(6, 0);

        // All requesters for eight cycles, pointer starting from reset
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, pack4(12'h430 + 12'(k), 12'h420 + 12'(k), 12'h410 + 12'(k), 12'h400 + 12'(k)),
                          1'b0, G_EXP[k], -1, 0);
        end
        idle(8, -1);
        checkOutput("busy_final", busy, 0);
        checkOutput("rd_q_empty", rd_q.size(), 0);
        checkOutput("rsp_q_empty", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
